// File: rtl/inv_shift_sequencer.sv
// Burst scheduler in front of the byte-serial inverse-ShiftRows datapath: buffers up to
// two blocks, issues unbroken 16-byte bursts and frames the returned bytes.
// Defining INV_SEQ_STATS_EN adds the blk_count completed-block counter port.

module inv_shift_sequencer #(
    parameter int DP_LATENCY = 12,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  dp_byte,
    output logic        dp_start,
    input  logic [7:0]  dp_out,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        out_first,
    output logic        out_last,
    output logic        busy
`ifdef INV_SEQ_STATS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    localparam int         FIFO_DEPTH  = 32;
    localparam logic [5:0] FIFO_FULL   = 6'd32;
    localparam logic [5:0] BLOCK_BYTES = 6'd16;
    localparam logic [3:0] LAST_IDX    = 4'd15;
    localparam logic       GAP_EN      = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST    = GAP_EN ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        idx_r;
    logic [3:0]        idx_next_s;
    logic [3:0]        gap_r;
    logic [3:0]        gap_next_s;

    logic [7:0]        fifo_mem_r [FIFO_DEPTH];
    logic [4:0]        wr_ptr_r;
    logic [4:0]        rd_ptr_r;
    logic [5:0]        count_r;
    logic [5:0]        count_next_s;
    logic              push_s;
    logic              pop_s;
    logic              blk_ready_s;
    logic [7:0]        head_s;

    logic [DP_LATENCY:0] mk_valid_r;
    logic [DP_LATENCY:0] mk_first_r;
    logic [DP_LATENCY:0] mk_last_r;
    logic [DP_LATENCY:0] mk_valid_next_s;
    logic [DP_LATENCY:0] mk_first_next_s;
    logic [DP_LATENCY:0] mk_last_next_s;

    logic [7:0]        dp_byte_r;
    logic              dp_start_r;
    logic [7:0]        out_byte_r;
    logic              out_valid_r;
    logic              out_first_r;
    logic              out_last_r;
    logic              busy_r;
    logic              busy_next_s;

    // in_ready is held low during reset and otherwise reflects the pre-edge occupancy
    assign in_ready     = ~reset & (count_r < FIFO_FULL);
    assign push_s       = in_valid & in_ready;
    assign pop_s        = (state_r == ST_BURST);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign count_next_s = count_r + {5'd0, push_s} - {5'd0, pop_s};
    assign blk_ready_s  = (count_next_s >= BLOCK_BYTES);

    assign mk_valid_next_s = {mk_valid_r[DP_LATENCY-1:0], pop_s};
    assign mk_first_next_s = {mk_first_r[DP_LATENCY-1:0], pop_s & (idx_r == 4'd0)};
    assign mk_last_next_s  = {mk_last_r[DP_LATENCY-1:0],  pop_s & (idx_r == LAST_IDX)};

    assign busy_next_s = (count_next_s != 6'd0) | (state_next_s != ST_IDLE) |
                         (|mk_valid_next_s) | mk_valid_r[DP_LATENCY];

    // FIFO storage: data array needs no reset, pointers define what is valid
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_byte;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= 5'd0;
            rd_ptr_r <= 5'd0;
            count_r  <= 6'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 5'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 5'd1;
            end
            count_r <= count_next_s;
        end
    end

    // Scheduler state, burst byte index and gap counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            gap_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            gap_r   <= gap_next_s;
        end
    end

    // Next-state: a burst is only launched once a whole block is buffered
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        gap_next_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r >= BLOCK_BYTES) begin
                    state_next_s = ST_BURST;
                    idx_next_s   = 4'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (idx_r == LAST_IDX) begin
                    idx_next_s = 4'd0;
                    if (GAP_EN) begin
                        state_next_s = ST_GAP;
                        gap_next_s   = 4'd0;
                    end else if (blk_ready_s) begin
                        state_next_s = ST_BURST;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    idx_next_s = idx_r + 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    gap_next_s = 4'd0;
                    idx_next_s = 4'd0;
                    if (blk_ready_s) begin
                        state_next_s = ST_BURST;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    gap_next_s = gap_r + 4'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = 4'd0;
                gap_next_s   = 4'd0;
            end
        endcase
    end

    // Datapath feed: head byte on pop cycles, zero otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_byte_r  <= 8'd0;
            dp_start_r <= 1'b0;
        end else begin
            dp_byte_r  <= pop_s ? head_s : 8'd0;
            dp_start_r <= pop_s & (idx_r == 4'd0);
        end
    end

    // Marker pipeline shadows the datapath latency so framing lines up with out_byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mk_valid_r <= '0;
            mk_first_r <= '0;
            mk_last_r  <= '0;
        end else begin
            mk_valid_r <= mk_valid_next_s;
            mk_first_r <= mk_first_next_s;
            mk_last_r  <= mk_last_next_s;
        end
    end

    // Output framing and activity flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_byte_r  <= 8'd0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_byte_r  <= dp_out;
            out_valid_r <= mk_valid_r[DP_LATENCY];
            out_first_r <= mk_first_r[DP_LATENCY];
            out_last_r  <= mk_last_r[DP_LATENCY];
            busy_r      <= busy_next_s;
        end
    end

`ifdef INV_SEQ_STATS_EN
    logic [15:0] blk_count_r;

    // Completed-block counter steps together with out_last and wraps naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_count_r <= 16'd0;
        end else if (mk_last_r[DP_LATENCY]) begin
            blk_count_r <= blk_count_r + 16'd1;
        end else begin
            blk_count_r <= blk_count_r;
        end
    end

    assign blk_count = blk_count_r;
`endif

    assign dp_byte   = dp_byte_r;
    assign dp_start  = dp_start_r;
    assign out_byte  = out_byte_r;
    assign out_valid = out_valid_r;
    assign out_first = out_first_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule
